german_rule_scheduler: RTL and testbench

//  Upstream driver for the generated German-protocol `system` block: each cycle it emits the
//  5-bit rule index on io_en_a that `system` executes. Three sources: round-robin sweep,

---
 rtl/german_sched_pkg.sv | 27 ++
 rtl/german_sched_fifo.sv | 57 +++++
 rtl/german_rule_scheduler.sv | 149 ++++++++++++++
 tb/tb_german_rule_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/german_sched_pkg.sv
// Shared types and constants for the German-protocol rule scheduler.
// Covers the mode/state encodings, the rule width and the LFSR tap mask.
package german_sched_pkg;

  localparam int RULE_W = 5;

  // The taps are x^16 + x^14 + x^13 + x^11, which are bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    MODE_RR     = 2'd0,
    MODE_RAND   = 2'd1,
    MODE_SCRIPT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RUN_RR     = 2'd1,
    ST_RUN_RAND   = 2'd2,
    ST_RUN_SCRIPT = 2'd3
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return {value[14:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/german_sched_fifo.sv
// Small synchronous script FIFO with first-word fall-through read.
// Full and empty are derived only from the registered count, so there is no same-cycle bypass.
module german_sched_fifo
  import german_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = RULE_W
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/german_rule_scheduler.sv
// Chooses the rule that `system` fires each cycle. The rule comes from a round-robin sweep,
// from an LFSR walk or from a scripted FIFO, and it is registered onto io_en_a.
module german_rule_scheduler
  import german_sched_pkg::*;
#(
  parameter int          NUM_RULES  = 20,
  parameter int          NOP_RULE   = 31,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_run,
  input  logic [1:0]        io_mode,
  input  logic              io_seed_load,
  input  logic [15:0]       io_seed,
  input  logic              io_scr_valid,
  output logic              io_scr_ready,
  input  logic [RULE_W-1:0] io_scr_rule,
  output logic [RULE_W-1:0] io_en_a,
  output logic              io_en_valid,
  output logic              io_starved,
  output logic [31:0]       io_fire_cnt
);

  localparam logic [RULE_W-1:0] NOP  = RULE_W'(NOP_RULE);
  localparam logic [RULE_W-1:0] NR   = RULE_W'(NUM_RULES);
  localparam logic [RULE_W-1:0] LAST = RULE_W'(NUM_RULES - 1);

  state_e            state_reg, state_next;
  logic [RULE_W-1:0] en_a_reg, en_a_next;
  logic              en_valid_reg, en_valid_next;
  logic              starved_reg, starved_next;
  logic [31:0]       fire_cnt_reg, fire_cnt_next;
  logic [15:0]       lfsr_reg, lfsr_next;
  logic [RULE_W-1:0] ptr_reg, ptr_next;

  logic              fifo_pop;
  logic [RULE_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [RULE_W-1:0] rand_raw;
  logic [RULE_W-1:0] rand_idx;

  german_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RULE_W)
  ) u_fifo (
    .clk       (clock),
    .srst      (reset),
    .push      (io_scr_valid),
    .push_data (io_scr_rule),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign io_scr_ready = !fifo_full;

  // A single subtraction is enough, because 31 - NUM_RULES < NUM_RULES whenever NUM_RULES >= 16.
  assign rand_raw = lfsr_reg[RULE_W-1:0];
  assign rand_idx = (rand_raw >= NR) ? (rand_raw - NR) : rand_raw;

  always_comb begin
    state_next    = state_reg;
    en_a_next     = NOP;
    en_valid_next = 1'b0;
    starved_next  = 1'b0;
    lfsr_next     = lfsr_reg;
    ptr_next      = ptr_reg;
    fifo_pop      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (io_seed_load) begin
          lfsr_next = (io_seed == 16'h0000) ? LFSR_SEED : io_seed;
        end
        if (io_run) begin
          case (io_mode)
            MODE_RAND:   state_next = ST_RUN_RAND;
            MODE_SCRIPT: state_next = ST_RUN_SCRIPT;
            default:     state_next = ST_RUN_RR;
          endcase
        end
      end
      ST_RUN_RR: begin
        if (!io_run) begin
          state_next = ST_IDLE;
        end else begin
          en_a_next     = ptr_reg;
          en_valid_next = 1'b1;
          ptr_next      = (ptr_reg == LAST) ? '0 : ptr_reg + RULE_W'(1);
        end
      end
      ST_RUN_RAND: begin
        if (!io_run) begin
          state_next = ST_IDLE;
        end else begin
          en_a_next     = rand_idx;
          en_valid_next = 1'b1;
          lfsr_next     = lfsr_step(lfsr_reg);
        end
      end
      ST_RUN_SCRIPT: begin
        if (!io_run) begin
          state_next = ST_IDLE;
        end else if (fifo_empty) begin
          starved_next = 1'b1;
        end else begin
          fifo_pop = 1'b1;
          // An out-of-range script entry still uses up its slot, but it is issued as a NOP.
          if (fifo_data < NR) begin
            en_a_next     = fifo_data;
            en_valid_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    fire_cnt_next = (en_valid_next && (fire_cnt_reg != 32'hFFFF_FFFF))
                    ? fire_cnt_reg + 32'd1 : fire_cnt_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      en_a_reg     <= NOP;
      en_valid_reg <= 1'b0;
      starved_reg  <= 1'b0;
      fire_cnt_reg <= '0;
      lfsr_reg     <= LFSR_SEED;
      ptr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      en_a_reg     <= en_a_next;
      en_valid_reg <= en_valid_next;
      starved_reg  <= starved_next;
      fire_cnt_reg <= fire_cnt_next;
      lfsr_reg     <= lfsr_next;
      ptr_reg      <= ptr_next;
    end
  end

  assign io_en_a     = en_a_reg;
  assign io_en_valid = en_valid_reg;
  assign io_starved  = starved_reg;
  assign io_fire_cnt = fire_cnt_reg;

endmodule

// File: tb/tb_german_rule_scheduler.sv
// Bench for the rule scheduler: directed scenarios followed by random traffic.
// Every output is compared each cycle against a queue-based behavioural model.
module tb_german_rule_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_run = 1'b0;
  logic [1:0]  io_mode = 2'd0;
  logic        io_seed_load = 1'b0;
  logic [15:0] io_seed = 16'h0;
  logic        io_scr_valid = 1'b0;
  logic        io_scr_ready;
  logic [4:0]  io_scr_rule = 5'd0;
  logic [4:0]  io_en_a;
  logic        io_en_valid;
  logic        io_starved;
  logic [31:0] io_fire_cnt;

  int vectors = 0;
  int miscompares = 0;

  german_rule_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .io_run       (io_run),
    .io_mode      (io_mode),
    .io_seed_load (io_seed_load),
    .io_seed      (io_seed),
    .io_scr_valid (io_scr_valid),
    .io_scr_ready (io_scr_ready),
    .io_scr_rule  (io_scr_rule),
    .io_en_a      (io_en_a),
    .io_en_valid  (io_en_valid),
    .io_starved   (io_starved),
    .io_fire_cnt  (io_fire_cnt)
  );

  always #5 clock = ~clock;

  // The model state is 0 for idle, 1 for round-robin, 2 for random and 3 for script.
  int          m_state = 0;
  int          m_ptr = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_q[$];
  int          m_en_a = 31;
  bit          m_valid = 0;
  bit          m_starved = 0;
  logic [31:0] m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    int  taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= v[taps[i]-1];
    return {v[14:0], fb};
  endfunction

  task automatic model_update();
    bit was_full;
    int v;
    if (reset) begin
      m_state = 0; m_ptr = 0; m_lfsr = 16'hACE1; m_q.delete();
      m_en_a = 31; m_valid = 0; m_starved = 0; m_cnt = 0;
      return;
    end
    was_full = (m_q.size() >= 8);
    m_en_a = 31; m_valid = 0; m_starved = 0;
    if (m_state == 0) begin
      if (io_seed_load) m_lfsr = (io_seed == 0) ? 16'hACE1 : io_seed;
      if (io_run) m_state = (io_mode == 1) ? 2 : (io_mode == 2) ? 3 : 1;
    end else if (!io_run) begin
      m_state = 0;
    end else if (m_state == 1) begin
      m_en_a = m_ptr; m_valid = 1; m_ptr = (m_ptr + 1) % 20;
    end else if (m_state == 2) begin
      v = int'(m_lfsr) % 32;
      if (v >= 20) v -= 20;
      m_en_a = v; m_valid = 1; m_lfsr = ref_step(m_lfsr);
    end else begin
      if (m_q.size() == 0) m_starved = 1;
      else begin
        v = m_q.pop_front();
        if (v < 20) begin m_en_a = v; m_valid = 1; end
      end
    end
    if (io_scr_valid && !was_full) m_q.push_back(int'(io_scr_rule));
    if (m_valid && m_cnt != 32'hFFFF_FFFF) m_cnt++;
  endtask

  task automatic cyc();
    @(posedge clock);
    model_update();
    #1;
    check("en_a", 32'(io_en_a), 32'(m_en_a));
    check("en_valid", 32'(io_en_valid), 32'(m_valid));
    check("starved", 32'(io_starved), 32'(m_starved));
    check("fire_cnt", io_fire_cnt, m_cnt);
    check("scr_ready", 32'(io_scr_ready), 32'(m_q.size() < 8));
  endtask

  task automatic do_reset();
    reset = 1'b1; io_run = 1'b0; io_scr_valid = 1'b0; io_seed_load = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    int exp_seq[5] = '{31, 8, 3, 31, 0};
    int exp_vld[5] = '{0, 1, 1, 0, 1};
    int pushes[4]  = '{8, 3, 25, 0};

    // Check the reset state.
    do_reset();
    check("rst_en_a", 32'(io_en_a), 32'd31);
    check("rst_valid", 32'(io_en_valid), 32'd0);
    check("rst_cnt", io_fire_cnt, 32'd0);
    check("rst_ready", 32'(io_scr_ready), 32'd1);

    // Round-robin sweep with a wrap, 23 cycles of run.
    io_mode = 2'd0; io_run = 1'b1;
    for (int i = 0; i < 23; i++) begin
      cyc();
      check("rr_seq", 32'(io_en_a), (i == 0) ? 32'd31 : 32'((i - 1) % 20));
    end
    check("rr_cnt", io_fire_cnt, 32'd22);
    io_run = 1'b0; cyc();

    // Random walk from seed 1, then from seed 0, which falls back to 0xACE1.
    for (int s = 0; s < 2; s++) begin
      io_seed_load = 1'b1; io_seed = (s == 0) ? 16'h0001 : 16'h0000; cyc();
      io_seed_load = 1'b0; io_mode = 2'd1; io_run = 1'b1;
      for (int i = 0; i < 30; i++) begin
        cyc();
        if (i > 0) check("rand_range", 32'(io_en_a < 5'd20), 32'd1);
      end
      io_run = 1'b0; cyc();
    end

    // Scripted entries 8, 3, 25, 0, followed by starvation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      io_scr_valid = 1'b1; io_scr_rule = 5'(pushes[i]); cyc();
    end
    io_scr_valid = 1'b0; io_mode = 2'd2; io_run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("scr_seq", 32'(io_en_a), 32'(exp_seq[i]));
      check("scr_vld", 32'(io_en_valid), 32'(exp_vld[i]));
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("scr_starved", 32'(io_starved), 32'd1);
    end
    io_run = 1'b0; cyc();

    // Fill the FIFO past full, then pop while it is full and a push is pending.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("ninth_ready", 32'(io_scr_ready), 32'd0);
      io_scr_valid = 1'b1; io_scr_rule = 5'(i); cyc();
    end
    io_mode = 2'd2; io_run = 1'b1;
    repeat (12) cyc();
    io_run = 1'b0; io_scr_valid = 1'b0; cyc();

    // Reset in the middle of a random run with three entries queued.
    do_reset();
    io_mode = 2'd1; io_run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      io_scr_valid = 1'b1; io_scr_rule = 5'(i + 4); cyc();
    end
    io_scr_valid = 1'b0; cyc();
    reset = 1'b1; cyc();
    check("mid_rst_en_a", 32'(io_en_a), 32'd31);
    check("mid_rst_cnt", io_fire_cnt, 32'd0);
    check("mid_rst_ready", 32'(io_scr_ready), 32'd1);
    reset = 1'b0; io_run = 1'b0; cyc();
    io_mode = 2'd2; io_run = 1'b1; cyc(); cyc();
    check("mid_rst_empty", 32'(io_starved), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) begin
        io_run = ~io_run;
        io_mode = 2'($urandom_range(0, 3));
      end
      io_seed_load = ($urandom_range(0, 7) == 0);
      io_seed = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      io_scr_valid = 1'($urandom);
      io_scr_rule = 5'($urandom_range(0, 31));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
